// File: rtl/lcd_char_engine.sv
// lcd_char_engine: HD44780-style character LCD driver in 4-bit mode.
// Runs the power-on init sequence by itself, then serves one typed command
// at a time (character, raw instruction, cursor set, clear).
//
// Command handshake: a command transfers on a rising clk edge where
// cmd_valid & cmd_ready are both high. cmd_ready is high only while the
// engine is idle and drops on the cycle after a transfer. cmd_* are captured
// at the transfer edge, so the source may change them afterwards. cmd_valid
// is ignored while cmd_ready is low, and nothing is queued.
module lcd_char_engine #(
  parameter int         CLK_MHZ   = 50,
  parameter int         COLS      = 16,
  parameter int         LINES     = 2,
  parameter logic [7:0] ROW1_BASE = 8'h40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  input  logic       cmd_row,
  input  logic [5:0] cmd_col,
  output logic       init_done,
  output logic [3:0] SF_D,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW
);

  // All delays are in clock cycles: microseconds x CLK_MHZ.
  localparam int T_PWR   = 15000 * CLK_MHZ;
  localparam int T_4100  = 4100 * CLK_MHZ;
  localparam int T_100   = 100 * CLK_MHZ;
  localparam int T_40    = 40 * CLK_MHZ;
  localparam int T_1640  = 1640 * CLK_MHZ;
  localparam int T_GAP   = 1 * CLK_MHZ;
  // Enable pulse is at least 240 ns, never shorter than 12 cycles.
  localparam int STB_RAW = (24 * CLK_MHZ + 99) / 100;
  localparam int T_STB   = (STB_RAW > 12) ? STB_RAW : 12;
  localparam int DW      = $clog2(T_PWR + 1);
  localparam int NW      = $clog2(T_STB + 1);

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT_NIB,
    S_INIT_WAIT,
    S_BYTE_HI,
    S_BYTE_GAP,
    S_BYTE_LO,
    S_BYTE_POST,
    S_IDLE
  } top_state_t;

  typedef enum logic [1:0] {
    N_IDLE,
    N_SETUP,
    N_STROBE,
    N_HOLD
  } nib_state_t;

  top_state_t     state, state_nx;
  nib_state_t     nib_state, nib_nx;

  logic [DW-1:0]  dly_cnt;
  logic [DW-1:0]  dly_target;
  logic           dly_done;
  logic           in_wait;
  logic [NW-1:0]  nib_cnt;
  logic           nib_go;
  logic           nib_done;
  logic [3:0]     nib_data;
  logic           nib_rs;

  logic [1:0]     init_idx;
  logic [1:0]     cfg_idx;
  logic           in_cfg;
  logic [7:0]     xfer_byte;
  logic           xfer_rs;
  logic           post_long;

  logic           init_adv;
  logic           cfg_start;
  logic           cfg_adv;
  logic           cfg_finish;
  logic           cmd_accept;

  logic [6:0]     col_ext;
  logic [6:0]     col_clamp;
  logic           row_clamp;
  logic [6:0]     ddram_addr;
  logic [7:0]     cmd_byte;

  // Configuration bytes written after the nibble-mode wake-up.
  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_byte = 8'h28;
      2'd1:    cfg_byte = 8'h06;
      2'd2:    cfg_byte = 8'h0C;
      default: cfg_byte = 8'h01;
    endcase
  endfunction

  // Translate the incoming command into the byte that goes to the panel.
  always_comb begin
    col_ext    = {1'b0, cmd_col};
    col_clamp  = (col_ext >= 7'(COLS)) ? 7'(COLS - 1) : col_ext;
    row_clamp  = (LINES > 1) ? cmd_row : 1'b0;
    ddram_addr = (row_clamp ? ROW1_BASE[6:0] : 7'h00) + col_clamp;
    case (cmd_type)
      2'b00, 2'b01: cmd_byte = cmd_data;
      2'b10:        cmd_byte = {1'b1, ddram_addr};
      default:      cmd_byte = 8'h01;
    endcase
  end

  // Clear and return-home instructions need the long settle time.
  assign post_long = !xfer_rs && ((xfer_byte == 8'h01) || (xfer_byte == 8'h02));

  // Length of the current wait state, expressed as its final count value.
  always_comb begin
    dly_target = '0;
    case (state)
      S_PWR_WAIT:  dly_target = DW'(T_PWR - 1);
      S_INIT_WAIT: begin
        case (init_idx)
          2'd0:    dly_target = DW'(T_4100 - 1);
          2'd1:    dly_target = DW'(T_100 - 1);
          default: dly_target = DW'(T_40 - 1);
        endcase
      end
      S_BYTE_GAP:  dly_target = DW'(T_GAP - 1);
      S_BYTE_POST: dly_target = post_long ? DW'(T_1640 - 1) : DW'(T_40 - 1);
      default:     dly_target = '0;
    endcase
  end

  assign dly_done = (dly_cnt == dly_target);
  assign in_wait  = (state == S_PWR_WAIT) || (state == S_INIT_WAIT) ||
                    (state == S_BYTE_GAP) || (state == S_BYTE_POST);

  // Top state register plus the sequencing registers it steers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_PWR_WAIT;
      dly_cnt   <= '0;
      init_idx  <= 2'd0;
      cfg_idx   <= 2'd0;
      in_cfg    <= 1'b0;
      xfer_byte <= 8'h00;
      xfer_rs   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        dly_cnt <= '0;
      end else if (in_wait) begin
        dly_cnt <= dly_cnt + DW'(1);
      end
      if (init_adv) begin
        init_idx <= init_idx + 2'd1;
      end
      if (cfg_start) begin
        in_cfg    <= 1'b1;
        cfg_idx   <= 2'd0;
        xfer_byte <= cfg_byte(2'd0);
        xfer_rs   <= 1'b0;
      end
      if (cfg_adv) begin
        cfg_idx   <= cfg_idx + 2'd1;
        xfer_byte <= cfg_byte(cfg_idx + 2'd1);
      end
      if (cfg_finish) begin
        in_cfg    <= 1'b0;
        init_done <= 1'b1;
      end
      if (cmd_accept) begin
        xfer_byte <= cmd_byte;
        xfer_rs   <= (cmd_type == 2'b00);
      end
    end
  end

  // Top next-state logic and one-cycle sequencing strobes.
  always_comb begin
    state_nx   = state;
    init_adv   = 1'b0;
    cfg_start  = 1'b0;
    cfg_adv    = 1'b0;
    cfg_finish = 1'b0;
    cmd_accept = 1'b0;
    case (state)
      S_PWR_WAIT:  if (dly_done) state_nx = S_INIT_NIB;
      S_INIT_NIB:  if (nib_done) state_nx = S_INIT_WAIT;
      S_INIT_WAIT: begin
        if (dly_done) begin
          if (init_idx == 2'd3) begin
            state_nx  = S_BYTE_HI;
            cfg_start = 1'b1;
          end else begin
            state_nx = S_INIT_NIB;
            init_adv = 1'b1;
          end
        end
      end
      S_BYTE_HI:   if (nib_done) state_nx = S_BYTE_GAP;
      S_BYTE_GAP:  if (dly_done) state_nx = S_BYTE_LO;
      S_BYTE_LO:   if (nib_done) state_nx = S_BYTE_POST;
      S_BYTE_POST: begin
        if (dly_done) begin
          if (in_cfg && (cfg_idx != 2'd3)) begin
            state_nx = S_BYTE_HI;
            cfg_adv  = 1'b1;
          end else begin
            state_nx   = S_IDLE;
            cfg_finish = in_cfg;
          end
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          state_nx   = S_BYTE_HI;
          cmd_accept = 1'b1;
        end
      end
      default: state_nx = S_PWR_WAIT;
    endcase
  end

  // Top outputs: ready flag and the nibble request for the shared writer.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    nib_go    = 1'b0;
    nib_data  = 4'h0;
    nib_rs    = 1'b0;
    case (state)
      S_INIT_NIB: begin
        nib_go   = 1'b1;
        nib_data = (init_idx == 2'd3) ? 4'h2 : 4'h3;
      end
      S_BYTE_HI: begin
        nib_go   = 1'b1;
        nib_data = xfer_byte[7:4];
        nib_rs   = xfer_rs;
      end
      S_BYTE_LO: begin
        nib_go   = 1'b1;
        nib_data = xfer_byte[3:0];
        nib_rs   = xfer_rs;
      end
      default: ;
    endcase
  end

  // Nibble writer registers; data and RS are captured once per nibble so
  // they cannot move while EN is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      nib_state <= N_IDLE;
      nib_cnt   <= '0;
      SF_D      <= 4'h0;
      LCD_RS    <= 1'b0;
    end else begin
      nib_state <= nib_nx;
      if (nib_nx != nib_state) begin
        nib_cnt <= '0;
      end else if ((nib_state == N_SETUP) || (nib_state == N_STROBE)) begin
        nib_cnt <= nib_cnt + NW'(1);
      end
      if ((nib_state == N_IDLE) && nib_go) begin
        SF_D   <= nib_data;
        LCD_RS <= nib_rs;
      end
    end
  end

  // Nibble writer sequencing: setup 2 cycles, strobe T_STB cycles, hold 1.
  always_comb begin
    nib_nx = nib_state;
    case (nib_state)
      N_IDLE:   if (nib_go) nib_nx = N_SETUP;
      N_SETUP:  if (nib_cnt == NW'(1)) nib_nx = N_STROBE;
      N_STROBE: if (nib_cnt == NW'(T_STB - 1)) nib_nx = N_HOLD;
      default:  nib_nx = N_IDLE;
    endcase
  end

  assign nib_done = (nib_state == N_HOLD);
  assign LCD_EN   = (nib_state == N_STROBE);
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_char_engine.sv
// Testbench for lcd_char_engine at CLK_MHZ=1 so microseconds equal cycles.
module tb_lcd_char_engine;

  localparam int         CLK_MHZ   = 1;
  localparam int         COLS      = 16;
  localparam int         LINES     = 2;
  localparam logic [7:0] ROW1_BASE = 8'h40;
  localparam int         EN_WIDTH  = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_row = 1'b0;
  logic [5:0] cmd_col = 6'd0;
  logic       init_done;
  logic [3:0] SF_D;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;

  lcd_char_engine #(
    .CLK_MHZ  (CLK_MHZ),
    .COLS     (COLS),
    .LINES    (LINES),
    .ROW1_BASE(ROW1_BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_type (cmd_type),
    .cmd_data (cmd_data),
    .cmd_row  (cmd_row),
    .cmd_col  (cmd_col),
    .init_done(init_done),
    .SF_D     (SF_D),
    .LCD_EN   (LCD_EN),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [4:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int last_fall_cyc = 0;
  int first_rise_cyc = -1;
  bit want_first = 1'b0;
  bit done_flag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_ge(input string name, input int act, input int min_val);
    n_checks++;
    if (act >= min_val) n_pass++;
    else $display("FAIL %s: got %0d expected at least %0d", name, act, min_val);
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_checks++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  // Returns {rs, byte} for a command from the command rules.
  function automatic logic [8:0] model(input int t, input int d, input int r, input int c);
    int rr, cc, addr;
    case (t)
      0: model = {1'b1, 8'(d)};
      1: model = {1'b0, 8'(d)};
      2: begin
        rr = (r > LINES - 1) ? LINES - 1 : r;
        cc = (c > COLS - 1) ? COLS - 1 : c;
        addr = ((rr == 1 ? int'(ROW1_BASE) : 0) + cc) % 128;
        model = {1'b0, 8'(128 + addr)};
      end
      default: model = 9'h001;
    endcase
  endfunction

  function automatic int post_wait(input logic [8:0] rb);
    if (!rb[8] && (rb[7:0] == 8'h01 || rb[7:0] == 8'h02)) post_wait = 1640 * CLK_MHZ;
    else post_wait = 40 * CLK_MHZ;
  endfunction

  task automatic push_byte(input logic rs, input logic [7:0] b);
    exp_q.push_back({rs, b[7:4]});
    exp_q.push_back({rs, b[3:0]});
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic en_q;
    logic [4:0] cap;
    logic [4:0] e;
    int en_width;
    bit unstable;
    en_q = 1'b0;
    cap = '0;
    en_width = 0;
    unstable = 1'b0;
    forever begin
      @(negedge clk);
      if (LCD_EN === 1'b1 && !en_q) begin
        cap = {LCD_RS, SF_D};
        en_width = 1;
        unstable = 1'b0;
        if (want_first) begin
          first_rise_cyc = cyc;
          want_first = 1'b0;
        end
        if (exp_q.size() == 0) fail_now("nibble_unexpected", int'(cap), -1);
        else begin
          e = exp_q.pop_front();
          check("nibble", 32'(cap), 32'(e));
        end
      end else if (LCD_EN === 1'b1 && en_q) begin
        en_width++;
        if ({LCD_RS, SF_D} !== cap) unstable = 1'b1;
      end else if (LCD_EN !== 1'b1 && en_q) begin
        last_fall_cyc = cyc;
        if (!reset) begin
          check("en_width", 32'(en_width), 32'(EN_WIDTH));
          check("data_stable", 32'(unstable), 32'd0);
          check("lcd_rw", 32'(LCD_RW), 32'd0);
        end
      end
      en_q = (LCD_EN === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic reset_and_init();
    reset = 1'b1;
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_sf_d", 32'(SF_D), 32'd0);
    check("rst_en", 32'(LCD_EN), 32'd0);
    check("rst_rs", 32'(LCD_RS), 32'd0);
    check("rst_rw", 32'(LCD_RW), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    exp_q.delete();
    first_rise_cyc = -1;
    want_first = 1'b1;
    reset = 1'b0;
    begin
      int c0;
      int n;
      c0 = cyc;
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h03);
      exp_q.push_back(5'h02);
      push_byte(1'b0, 8'h28);
      push_byte(1'b0, 8'h06);
      push_byte(1'b0, 8'h0C);
      push_byte(1'b0, 8'h01);
      n = 0;
      while (init_done !== 1'b1 && n < 30000) begin
        @(negedge clk);
        n++;
      end
      check("init_done", 32'(init_done), 32'd1);
      check("init_done_delay", 32'(cyc - last_fall_cyc), 32'd1641);
      check_ge("first_rise", first_rise_cyc - c0, 15002);
      check("init_left", 32'(exp_q.size()), 32'd0);
      check("init_ready", 32'(cmd_ready), 32'd1);
    end
  endtask

  // Issue one command; with hold_valid the valid line stays high with
  // junk fields during the transfer, which must be ignored.
  task automatic send_cmd(input int t, input int d, input int r, input int c, input bit hold_valid);
    logic [8:0] rb;
    wait_ready(5000);
    if (cmd_ready !== 1'b1) begin
      fail_now("ready_timeout_pre", 0, 1);
      return;
    end
    cmd_type = 2'(t);
    cmd_data = 8'(d);
    cmd_row = 1'(r);
    cmd_col = 6'(c);
    cmd_valid = 1'b1;
    rb = model(t, d, r, c);
    push_byte(rb[8], rb[7:0]);
    @(negedge clk);
    check("ready_drop", 32'(cmd_ready), 32'd0);
    if (hold_valid) begin
      cmd_type = 2'($urandom_range(0, 3));
      cmd_data = 8'($urandom_range(0, 255));
      cmd_col = 6'($urandom_range(0, 63));
    end else begin
      cmd_valid = 1'b0;
    end
    wait_ready(5000);
    if (cmd_ready !== 1'b1) fail_now("ready_timeout_post", 0, 1);
    else check("ready_return", 32'(cyc - last_fall_cyc), 32'(post_wait(rb) + 1));
  endtask

  task automatic send_random(input bit hold_valid);
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 3) send_cmd(0, $urandom_range(32, 126), 0, 0, hold_valid);
    else if (sel <= 5) send_cmd(1, $urandom_range(0, 255), 0, 0, hold_valid);
    else if (sel <= 8) send_cmd(2, 0, $urandom_range(0, 1), $urandom_range(0, 63), hold_valid);
    else send_cmd(3, 0, 0, 0, hold_valid);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_and_init();

    // Directed commands from the feature list.
    send_cmd(0, 8'h41, 0, 0, 1'b0);
    send_cmd(2, 0, 1, 5, 1'b0);
    send_cmd(2, 0, 1, 20, 1'b0);
    send_cmd(2, 0, 0, 63, 1'b0);
    send_cmd(3, 0, 0, 0, 1'b0);
    send_cmd(1, 8'h01, 0, 0, 1'b0);
    send_cmd(1, 8'h02, 0, 0, 1'b0);
    send_cmd(1, 8'h80, 0, 0, 1'b0);

    // Random commands with valid released between them.
    for (int i = 0; i < 20; i++) send_random(1'b0);

    // Back-to-back with valid held high throughout.
    for (int i = 0; i < 8; i++) send_random(1'b1);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("b2b_left", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a character strobe.
    wait_ready(5000);
    cmd_type = 2'b00;
    cmd_data = 8'h41;
    cmd_valid = 1'b1;
    push_byte(1'b1, 8'h41);
    @(negedge clk);
    cmd_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (LCD_EN !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    repeat (4) @(negedge clk);
    check("pre_abort_en", 32'(LCD_EN), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_en", 32'(LCD_EN), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    reset_and_init();

    send_cmd(0, 8'h5A, 0, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("final_left", 32'(exp_q.size()), 32'd0);

    done_flag = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (99000) @(posedge clk);
    if (!done_flag) begin
      fail_now("watchdog", cyc, 99000);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

endmodule
